// File: rtl/conv_window_sched_pkg.sv
// Shared types and default geometry for the convolution window scheduler.
package conv_window_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int KERNEL_DEF = 3;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;
  localparam int LAT_DEF    = 2;
  localparam int CW_DEF     = 8;

  // Output map side for stride 1, no padding.
  function automatic int out_dim(input int img, input int kernel);
    return img - kernel + 1;
  endfunction

endpackage

// File: rtl/conv_window_sched_win_counter.sv
// Row-major window origin counter; wraps to (0,0) after the last window.
module conv_window_sched_win_counter #(
  parameter int CW    = 8,
  parameter int OUT_W = 6,
  parameter int OUT_H = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(OUT_H - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Window scheduler for one ConvLayer_calc datapath over an IMG_H x IMG_W map.
// Define CONV_SCHED_STALL_EN to add win_valid gating of window issue.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing windows (calc_en)
// S_DRAIN | all windows issued, collecting en_out returns
// S_DONE  | one-cycle done pulse
module conv_window_sched
  import conv_window_sched_pkg::*;
#(
  parameter int KERNEL = KERNEL_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int LAT    = LAT_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef CONV_SCHED_STALL_EN
  input  logic            win_valid,
`endif
  output logic [CW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            calc_en,
  input  logic            calc_en_out,
  output logic            out_wr,
  output logic [2*CW-1:0] out_addr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int OUT_W = out_dim(IMG_W, KERNEL);
  localparam int OUT_H = out_dim(IMG_H, KERNEL);
  localparam int NWIN  = OUT_W * OUT_H;
  localparam int TW    = $clog2(LAT + 3);

  localparam logic [2*CW-1:0] NWIN_V   = (2*CW)'(NWIN);
  localparam logic [2*CW-1:0] ONE_W    = (2*CW)'(1);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(LAT + 2);
  localparam logic [TW-1:0]   TMO_ONE  = TW'(1);

  if (longint'(NWIN) >= (longint'(1) << (2*CW))) begin : g_nwin_check
    $error("conv_window_sched: NWIN does not fit in 2*CW bits");
  end

  state_t          state;
  logic            run_q;
  logic [2*CW-1:0] issued;
  logic [2*CW-1:0] ret;
  logic [2*CW-1:0] ret_next;
  logic [TW-1:0]   tmo;
  logic            last;
  logic            issue;
  logic            ret_ok;
  logic            spurious;

`ifdef CONV_SCHED_STALL_EN
  assign issue = run_q & win_valid;
`else
  assign issue = run_q;
`endif

  assign calc_en  = issue;
  // A return is only legal while a window is outstanding; anything else is flagged.
  assign ret_ok   = calc_en_out & busy & (issued != ret);
  assign spurious = calc_en_out & ~ret_ok;
  assign ret_next = ret + (ret_ok ? ONE_W : '0);
  assign out_wr   = ret_ok;
  assign out_addr = ret;

  conv_window_sched_win_counter #(
    .CW    (CW),
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_win_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == S_IDLE) && start),
    .inc  (issue),
    .row  (win_row),
    .col  (win_col),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      run_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      issued <= '0;
      ret    <= '0;
      tmo    <= '0;
    end else begin
      if (issue) issued <= issued + ONE_W;
      if (ret_ok) ret <= ret_next;
      if (spurious) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            run_q  <= 1'b1;
            busy   <= 1'b1;
            issued <= '0;
            ret    <= '0;
            err    <= 1'b0;
          end
        end
        S_RUN: begin
          if (issue && last) begin
            state <= S_DRAIN;
            run_q <= 1'b0;
            tmo   <= TMO_LOAD;
          end
        end
        S_DRAIN: begin
          // The timeout down-counter restarts on every return.
          if (ret_next == NWIN_V) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ret_ok) begin
            tmo <= TMO_LOAD;
          end else if (tmo == TMO_ONE) begin
            err   <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tmo <= tmo - TMO_ONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on a 6x6 map, 3x3 kernel, datapath latency 2.
module tb_conv_window_sched;

  localparam int CW = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic            win_valid;
  logic [CW-1:0]   win_row;
  logic [CW-1:0]   win_col;
  logic            calc_en;
  logic            calc_en_out;
  logic            out_wr;
  logic [2*CW-1:0] out_addr;
  logic            busy;
  logic            done;
  logic            err;

  int errors = 0;
  int checks = 0;

  logic       inject;
  logic       drop_last;
  logic [1:0] pv;
  logic [1:0] pd;

  conv_window_sched #(
    .KERNEL (3),
    .IMG_W  (6),
    .IMG_H  (6),
    .LAT    (2),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef CONV_SCHED_STALL_EN
    .win_valid   (win_valid),
`endif
    .win_row     (win_row),
    .win_col     (win_col),
    .calc_en     (calc_en),
    .calc_en_out (calc_en_out),
    .out_wr      (out_wr),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: en_out two cycles after en_in, optionally losing the (3,3) window.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= 2'b00;
      pd <= 2'b00;
    end else begin
      pv <= {pv[0], calc_en};
      pd <= {pd[0], drop_last && (win_row == 8'd3) && (win_col == 8'd3)};
    end
  end
  assign calc_en_out = (pv[1] && !pd[1]) || inject;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input string nm, input bit stall_pat, input bit extra_start,
                          input bit drop, input int abort_at, input int exp_done_cyc);
    int er, ec, n_iss, n_ret, first_iss, last_iss, done_cyc;
    bit pend;
    er = 0; ec = 0; n_iss = 0; n_ret = 0;
    first_iss = -1; last_iss = -1; done_cyc = -1; pend = 0;
    drop_last = drop;
    @(posedge clk); #1 start = 1'b1; win_valid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      win_valid = stall_pat ? ((cyc % 2) == 1) : 1'b1;
      start = pend;
      pend = 0;
      @(negedge clk);
      if (cyc == 1) begin
        chk({nm, " busy_first"}, busy, 1);
        chk({nm, " err_cleared"}, err, 0);
      end
      if (calc_en) begin
        chk({nm, " win_row"}, win_row, er);
        chk({nm, " win_col"}, win_col, ec);
        ec++;
        if (ec == 4) begin ec = 0; er++; end
        n_iss++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        if (extra_start && n_iss == 5) pend = 1;
        if (abort_at == n_iss) begin
          rst = 1'b1;
          #1;
          chk({nm, " rst_busy"}, busy, 0);
          chk({nm, " rst_calc_en"}, calc_en, 0);
          chk({nm, " rst_row"}, win_row, 0);
          chk({nm, " rst_col"}, win_col, 0);
          chk({nm, " rst_out_wr"}, out_wr, 0);
          chk({nm, " rst_out_addr"}, out_addr, 0);
          #2 rst = 1'b0;
          return;
        end
      end else if (busy && n_iss < 16) begin
        chk({nm, " hold_row"}, win_row, er);
        chk({nm, " hold_col"}, win_col, ec);
      end
      if (out_wr) begin
        chk({nm, " out_addr"}, out_addr, n_ret);
        n_ret++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, " done_cycle"}, done_cyc, exp_done_cyc);
    chk({nm, " n_issued"}, n_iss, 16);
    chk({nm, " n_returned"}, n_ret, drop ? 15 : 16);
    chk({nm, " err_end"}, err, drop);
    chk({nm, " first_issue"}, first_iss, 1);
    chk({nm, " last_issue"}, last_iss, stall_pat ? 31 : 16);
    drop_last = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, " done_pulse_end"}, done, 0);
    chk({nm, " busy_end"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_valid = 1'b0; inject = 1'b0; drop_last = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset calc_en", calc_en, 0);
    chk("reset win_row", win_row, 0);
    chk("reset win_col", win_col, 0);
    chk("reset out_wr", out_wr, 0);
    @(negedge clk);
    rst = 1'b0;

    run_pass("basic", 0, 0, 0, 0, 19);
`ifdef CONV_SCHED_STALL_EN
    run_pass("stall", 1, 0, 0, 0, 34);
`endif
    run_pass("restart_ignored", 0, 1, 0, 0, 19);

    @(posedge clk); #1 inject = 1'b1;
    @(negedge clk);
    chk("idle_inject out_wr", out_wr, 0);
    chk("idle_inject busy", busy, 0);
    @(posedge clk); #1 inject = 1'b0;
    @(negedge clk);
    chk("idle_inject err", err, 1);

    run_pass("drop_last", 0, 0, 1, 0, 22);
    run_pass("abort", 0, 0, 0, 7, 0);
    run_pass("after_rst", 0, 0, 0, 0, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
